// File: rtl/camera_capture_win.sv
// camera_capture_win: pixel capture front end for a parallel CMOS sensor with a per-frame crop window.
// Define CAMERA_CAPTURE_DECIM_EN to add the DECIM input (2x2 decimation latched at frame start).
module camera_capture_win #(
  parameter int H   = 752,
  parameter int V   = 480,
  parameter int DW  = 10,
  parameter int FCW = 8
) (
  input  logic                 PIXCLK,
  input  logic                 RST,
  input  logic                 LINE_VALID,
  input  logic                 FRAME_VALID,
  input  logic [DW-1:0]        DATA_IN,
  input  logic [$clog2(H)-1:0] WIN_X0,
  input  logic [$clog2(H)-1:0] WIN_X1,
  input  logic [$clog2(V)-1:0] WIN_Y0,
  input  logic [$clog2(V)-1:0] WIN_Y1,
`ifdef CAMERA_CAPTURE_DECIM_EN
  input  logic                 DECIM,
`endif
  output logic [DW-1:0]        DATA_OUT,
  output logic                 PIXEL_VALID,
  output logic [$clog2(H)-1:0] COLUMN,
  output logic [$clog2(V)-1:0] ROW,
  output logic                 SOF,
  output logic                 EOL,
  output logic                 EOF,
  output logic [FCW-1:0]       FRAME_COUNT,
  output logic                 OVERRUN
);

  localparam int CW = $clog2(H);
  localparam int RW = $clog2(V);
  localparam logic [CW-1:0] COL_MAX = CW'(H - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(V - 1);

  typedef enum logic [1:0] {SYNC, WAIT_FRAME, ACTIVE} state_t;

  state_t         state, state_nxt;
  logic           fv_q, lv_q;
  logic [CW-1:0]  col_cnt, col_cnt_nxt, cur_col, eol_col;
  logic [RW-1:0]  row_cnt, row_cnt_nxt;
  logic [CW-1:0]  x0, x1, x0_nxt, x1_nxt;
  logic [RW-1:0]  y0, y1, y0_nxt, y1_nxt;
  logic           sof_armed, sof_armed_nxt;
  logic           col_sat, col_sat_nxt, row_sat, row_sat_nxt;
  logic           sat_repeat, in_win;
  logic           pv_nxt, sof_nxt, eol_nxt, eof_nxt, ovr_nxt;
  logic [FCW-1:0] fc_nxt;
  logic [CW-1:0]  column_nxt;
  logic [RW-1:0]  row_out_nxt;
`ifdef CAMERA_CAPTURE_DECIM_EN
  logic           decim_q, decim_nxt;
`endif

  always_comb begin
    state_nxt     = state;
    col_cnt_nxt   = col_cnt;
    row_cnt_nxt   = row_cnt;
    x0_nxt        = x0;
    x1_nxt        = x1;
    y0_nxt        = y0;
    y1_nxt        = y1;
    sof_armed_nxt = sof_armed;
    col_sat_nxt   = col_sat;
    row_sat_nxt   = row_sat;
    pv_nxt        = 1'b0;
    sof_nxt       = 1'b0;
    eol_nxt       = 1'b0;
    eof_nxt       = 1'b0;
    ovr_nxt       = 1'b0;
    fc_nxt        = FRAME_COUNT;
    column_nxt    = COLUMN;
    row_out_nxt   = ROW;
    cur_col       = '0;
    sat_repeat    = 1'b0;
    in_win        = 1'b0;
`ifdef CAMERA_CAPTURE_DECIM_EN
    decim_nxt     = decim_q;
    eol_col       = decim_q ? {x1[CW-1:1], 1'b0} : x1;
`else
    eol_col       = x1;
`endif
    unique case (state)
      SYNC: begin
        if (!FRAME_VALID) state_nxt = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (FRAME_VALID && !fv_q) begin
          x0_nxt        = WIN_X0;
          x1_nxt        = WIN_X1;
          y0_nxt        = WIN_Y0;
          y1_nxt        = WIN_Y1;
`ifdef CAMERA_CAPTURE_DECIM_EN
          decim_nxt     = DECIM;
`endif
          col_cnt_nxt   = '0;
          row_cnt_nxt   = '0;
          column_nxt    = '0;
          row_out_nxt   = '0;
          sof_armed_nxt = 1'b1;
          col_sat_nxt   = 1'b0;
          row_sat_nxt   = 1'b0;
          state_nxt     = ACTIVE;
        end
      end
      ACTIVE: begin
        // Frame end wins over an open line: a truncated line does not advance the row.
        if (!FRAME_VALID) begin
          eof_nxt   = 1'b1;
          fc_nxt    = FRAME_COUNT + 1'b1;
          state_nxt = WAIT_FRAME;
        end else if (LINE_VALID) begin
          if (!lv_q) begin
            cur_col     = '0;
            col_sat_nxt = 1'b0;
          end else if (col_cnt == COL_MAX) begin
            cur_col    = COL_MAX;
            sat_repeat = 1'b1;
            if (!col_sat) begin
              ovr_nxt     = 1'b1;
              col_sat_nxt = 1'b1;
            end
          end else begin
            cur_col = col_cnt + 1'b1;
          end
          col_cnt_nxt = cur_col;
          in_win = (cur_col >= x0) && (cur_col <= x1) && (row_cnt >= y0) && (row_cnt <= y1);
`ifdef CAMERA_CAPTURE_DECIM_EN
          if (decim_q) in_win = in_win && !cur_col[0] && !row_cnt[0];
`endif
          pv_nxt      = in_win;
          eol_nxt     = in_win && (cur_col == eol_col) && !sat_repeat;
          sof_nxt     = in_win && sof_armed;
          if (in_win) sof_armed_nxt = 1'b0;
          column_nxt  = cur_col;
          row_out_nxt = row_cnt;
        end else if (lv_q) begin
          if (row_cnt == ROW_MAX) begin
            if (!row_sat) begin
              ovr_nxt     = 1'b1;
              row_sat_nxt = 1'b1;
            end
          end else begin
            row_cnt_nxt = row_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  // Every output is registered, so inputs sampled at one edge appear right after it.
  always_ff @(posedge PIXCLK or posedge RST) begin
    if (RST) begin
      state       <= SYNC;
      fv_q        <= 1'b0;
      lv_q        <= 1'b0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      x0          <= '0;
      x1          <= '0;
      y0          <= '0;
      y1          <= '0;
      sof_armed   <= 1'b0;
      col_sat     <= 1'b0;
      row_sat     <= 1'b0;
`ifdef CAMERA_CAPTURE_DECIM_EN
      decim_q     <= 1'b0;
`endif
      DATA_OUT    <= '0;
      PIXEL_VALID <= 1'b0;
      COLUMN      <= '0;
      ROW         <= '0;
      SOF         <= 1'b0;
      EOL         <= 1'b0;
      EOF         <= 1'b0;
      FRAME_COUNT <= '0;
      OVERRUN     <= 1'b0;
    end else begin
      state       <= state_nxt;
      fv_q        <= FRAME_VALID;
      lv_q        <= LINE_VALID;
      col_cnt     <= col_cnt_nxt;
      row_cnt     <= row_cnt_nxt;
      x0          <= x0_nxt;
      x1          <= x1_nxt;
      y0          <= y0_nxt;
      y1          <= y1_nxt;
      sof_armed   <= sof_armed_nxt;
      col_sat     <= col_sat_nxt;
      row_sat     <= row_sat_nxt;
`ifdef CAMERA_CAPTURE_DECIM_EN
      decim_q     <= decim_nxt;
`endif
      DATA_OUT    <= DATA_IN;
      PIXEL_VALID <= pv_nxt;
      COLUMN      <= column_nxt;
      ROW         <= row_out_nxt;
      SOF         <= sof_nxt;
      EOL         <= eol_nxt;
      EOF         <= eof_nxt;
      FRAME_COUNT <= fc_nxt;
      OVERRUN     <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_camera_capture_win.sv
// tb_camera_capture_win: bench for camera_capture_win at H=8, V=4 against a model that
// counts pixels per line and lines per frame directly.
module tb_camera_capture_win;
  localparam int H   = 8;
  localparam int V   = 4;
  localparam int DW  = 10;
  localparam int FCW = 8;
  localparam int CW  = $clog2(H);
  localparam int RW  = $clog2(V);

  logic          PIXCLK;
  logic          RST;
  logic          LINE_VALID;
  logic          FRAME_VALID;
  logic [DW-1:0] DATA_IN;
  logic [CW-1:0] WIN_X0, WIN_X1;
  logic [RW-1:0] WIN_Y0, WIN_Y1;
  logic [DW-1:0] DATA_OUT;
  logic          PIXEL_VALID;
  logic [CW-1:0] COLUMN;
  logic [RW-1:0] ROW;
  logic          SOF, EOL, EOF, OVERRUN;
  logic [FCW-1:0] FRAME_COUNT;

  int errors;
  int checks;

  // Reference model: mode 0 = not yet synced, 1 = between frames, 2 = inside a frame.
  int mMode, mX0, mX1, mY0, mY1, mLine, mPix, mFrames;
  bit mPrevFv, mPrevLv, mSofPending, mColOvfDone, mRowOvfDone;

  int pvCount, sofCount, eolCount, eofCount, ovrCount, sofCol, sofRow;

  camera_capture_win #(.H(H), .V(V), .DW(DW), .FCW(FCW)) dut (
    .PIXCLK(PIXCLK), .RST(RST), .LINE_VALID(LINE_VALID), .FRAME_VALID(FRAME_VALID),
    .DATA_IN(DATA_IN), .WIN_X0(WIN_X0), .WIN_X1(WIN_X1), .WIN_Y0(WIN_Y0), .WIN_Y1(WIN_Y1),
    .DATA_OUT(DATA_OUT), .PIXEL_VALID(PIXEL_VALID), .COLUMN(COLUMN), .ROW(ROW),
    .SOF(SOF), .EOL(EOL), .EOF(EOF), .FRAME_COUNT(FRAME_COUNT), .OVERRUN(OVERRUN)
  );

  always #5 PIXCLK = ~PIXCLK;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    mMode = 0; mPrevFv = 0; mPrevLv = 0; mFrames = 0; mLine = 0; mPix = 0;
    mSofPending = 0; mColOvfDone = 0; mRowOvfDone = 0;
  endtask

  task automatic clearCounts();
    pvCount = 0; sofCount = 0; eolCount = 0; eofCount = 0; ovrCount = 0;
    sofCol = -1; sofRow = -1;
  endtask

  task automatic setWindow(input int x0, input int x1, input int y0, input int y1);
    WIN_X0 = CW'(x0); WIN_X1 = CW'(x1); WIN_Y0 = RW'(y0); WIN_Y1 = RW'(y1);
  endtask

  task automatic randWindow();
    setWindow($urandom_range(0, H-1), $urandom_range(0, H-1),
              $urandom_range(0, V-1), $urandom_range(0, V-1));
  endtask

  // One clock: predict from the sensor-level rules, drive, then compare after the edge.
  task automatic applyStimulus(input bit fv, input bit lv);
    logic [DW-1:0] d;
    bit ePv, eSof, eEol, eEof, eOvr, inWin;
    int eCol, eRow;
    d = DW'($urandom);
    ePv = 0; eSof = 0; eEol = 0; eEof = 0; eOvr = 0; inWin = 0; eCol = 0; eRow = 0;
    if (mMode == 0) begin
      if (!fv) mMode = 1;
    end else if (mMode == 1) begin
      if (fv && !mPrevFv) begin
        mX0 = int'(WIN_X0); mX1 = int'(WIN_X1); mY0 = int'(WIN_Y0); mY1 = int'(WIN_Y1);
        mLine = 0; mPix = 0; mSofPending = 1; mRowOvfDone = 0; mMode = 2;
      end
    end else begin
      if (!fv) begin
        eEof = 1; mFrames++; mMode = 1;
      end else if (lv) begin
        if (!mPrevLv) begin mPix = 0; mColOvfDone = 0; end
        eCol = (mPix < H) ? mPix : H - 1;
        eRow = (mLine < V) ? mLine : V - 1;
        if (mPix >= H && !mColOvfDone) begin eOvr = 1; mColOvfDone = 1; end
        inWin = eCol >= mX0 && eCol <= mX1 && eRow >= mY0 && eRow <= mY1;
        ePv = inWin;
        eEol = inWin && mPix == mX1;
        eSof = inWin && mSofPending;
        if (inWin) mSofPending = 0;
        mPix++;
      end else if (mPrevLv) begin
        mLine++;
        if (mLine >= V && !mRowOvfDone) begin eOvr = 1; mRowOvfDone = 1; end
      end
    end
    mPrevFv = fv; mPrevLv = lv;
    FRAME_VALID = fv; LINE_VALID = lv; DATA_IN = d;
    @(posedge PIXCLK);
    #1;
    checkOutput("data_out", 32'(DATA_OUT), 32'(d));
    checkOutput("pixel_valid", 32'(PIXEL_VALID), 32'(ePv));
    checkOutput("sof", 32'(SOF), 32'(eSof));
    checkOutput("eol", 32'(EOL), 32'(eEol));
    checkOutput("eof", 32'(EOF), 32'(eEof));
    checkOutput("overrun", 32'(OVERRUN), 32'(eOvr));
    checkOutput("frame_count", 32'(FRAME_COUNT), 32'(mFrames % (1 << FCW)));
    if (ePv) begin
      checkOutput("column", 32'(COLUMN), 32'(eCol));
      checkOutput("row", 32'(ROW), 32'(eRow));
    end
    if (PIXEL_VALID === 1'b1) pvCount++;
    if (EOL === 1'b1) eolCount++;
    if (EOF === 1'b1) eofCount++;
    if (OVERRUN === 1'b1) ovrCount++;
    if (SOF === 1'b1) begin sofCount++; sofCol = int'(COLUMN); sofRow = int'(ROW); end
  endtask

  task automatic frameStart();
    applyStimulus(1, 0);
  endtask

  task automatic sendLine(input int n);
    for (int p = 0; p < n; p++) applyStimulus(1, 1);
    applyStimulus(1, 0);
    applyStimulus(1, 0);
  endtask

  task automatic frameEnd();
    applyStimulus(0, 0);
    applyStimulus(0, 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pv"}, 32'(PIXEL_VALID), 0);
    checkOutput({tag, "_fc"}, 32'(FRAME_COUNT), 0);
    checkOutput({tag, "_data"}, 32'(DATA_OUT), 0);
    checkOutput({tag, "_col"}, 32'(COLUMN), 0);
    checkOutput({tag, "_row"}, 32'(ROW), 0);
    checkOutput({tag, "_flags"}, 32'({SOF, EOL, EOF, OVERRUN}), 0);
  endtask

  initial begin
    errors = 0; checks = 0;
    PIXCLK = 0; RST = 1; LINE_VALID = 0; FRAME_VALID = 0; DATA_IN = '0;
    setWindow(0, H-1, 0, V-1);
    resetModel();
    clearCounts();
    #12;
    checkResetState("reset");

    // Release reset in the middle of a frame: the partial frame must be ignored.
    FRAME_VALID = 1;
    @(negedge PIXCLK);
    RST = 0;
    applyStimulus(1, 0);
    for (int l = 0; l < 3; l++) sendLine(H);
    frameEnd();
    checkOutput("sync_no_pv", 32'(pvCount), 0);
    clearCounts();
    frameStart();
    for (int l = 0; l < V; l++) sendLine(H);
    frameEnd();
    checkOutput("sync_frame_pv", 32'(pvCount), 32);
    checkOutput("sync_fc", 32'(FRAME_COUNT), 1);

    // Window X 2..5, Y 1..2.
    clearCounts();
    setWindow(2, 5, 1, 2);
    frameStart();
    for (int l = 0; l < V; l++) sendLine(H);
    frameEnd();
    checkOutput("win_pv_count", 32'(pvCount), 8);
    checkOutput("win_sof_count", 32'(sofCount), 1);
    checkOutput("win_sof_col", 32'(sofCol), 2);
    checkOutput("win_sof_row", 32'(sofRow), 1);
    checkOutput("win_eol_count", 32'(eolCount), 2);

    // Inverted X range: empty window, frame still counted.
    clearCounts();
    setWindow(6, 3, 0, V-1);
    frameStart();
    for (int l = 0; l < V; l++) sendLine(H);
    frameEnd();
    checkOutput("empty_pv", 32'(pvCount), 0);
    checkOutput("empty_sof", 32'(sofCount + eolCount), 0);
    checkOutput("empty_eof", 32'(eofCount), 1);
    checkOutput("empty_fc", 32'(FRAME_COUNT), 3);

    // Long line: column saturates, one overrun for the line.
    clearCounts();
    setWindow(0, H-1, 0, V-1);
    frameStart();
    sendLine(H + 3);
    sendLine(H);
    frameEnd();
    checkOutput("ovr_count", 32'(ovrCount), 1);
    checkOutput("ovr_pv", 32'(pvCount), 2 * H + 3);
    checkOutput("ovr_fc", 32'(FRAME_COUNT), 4);

    // Frame drops mid-line at column 4, then a clean frame starts at (0,0).
    clearCounts();
    frameStart();
    sendLine(H);
    for (int p = 0; p < 5; p++) applyStimulus(1, 1);
    applyStimulus(0, 1);
    checkOutput("trunc_eof", 32'(EOF), 1);
    checkOutput("trunc_pv_before", 32'(pvCount), H + 5);
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    checkOutput("trunc_pv_after", 32'(pvCount), H + 5);
    clearCounts();
    frameStart();
    sendLine(H);
    frameEnd();
    checkOutput("next_sof_col", 32'(sofCol), 0);
    checkOutput("next_sof_row", 32'(sofRow), 0);
    checkOutput("next_fc", 32'(FRAME_COUNT), 6);

    // Random windows, line lengths and mid-frame window changes.
    for (int f = 0; f < 6; f++) begin
      randWindow();
      frameStart();
      for (int l = 0; l < int'($urandom_range(1, V + 1)); l++) begin
        sendLine($urandom_range(1, H + 3));
        randWindow();
      end
      frameEnd();
    end
    checkOutput("rand_fc", 32'(FRAME_COUNT), 12);

    // Asynchronous reset mid-line: outputs clear at once and the frame is discarded.
    setWindow(0, H-1, 0, V-1);
    frameStart();
    sendLine(H);
    for (int p = 0; p < 3; p++) applyStimulus(1, 1);
    RST = 1;
    #2;
    checkResetState("midreset");
    resetModel();
    @(negedge PIXCLK);
    RST = 0;
    clearCounts();
    sendLine(H);
    sendLine(H);
    frameEnd();
    checkOutput("midreset_no_pv", 32'(pvCount), 0);
    checkOutput("midreset_fc", 32'(FRAME_COUNT), 0);

    // Frame counter wrap.
    for (int f = 1; f <= 257; f++) begin
      frameStart();
      sendLine(2);
      frameEnd();
      if (f == 255) checkOutput("wrap_255", 32'(FRAME_COUNT), 255);
      if (f == 256) checkOutput("wrap_0", 32'(FRAME_COUNT), 0);
      if (f == 257) checkOutput("wrap_1", 32'(FRAME_COUNT), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
